// File: rtl/lcd_pio_pkg.sv
// Shared types and constants for the LCD PIO consumer: FSM state encoding,
// the buffered command format, write-word field positions, status bit
// positions, the clear/home opcodes and the power-on init sequence.
package lcd_pio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    INIT_WAIT
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  // Field positions inside the stored 32-bit word
  localparam int WD_ON_BIT        = 31;
  localparam int WD_CTRL_ONLY_BIT = 30;
  localparam int WD_RS_BIT        = 8;

  // Status word bit positions
  localparam int ST_BUSY_BIT = 0;
  localparam int ST_FULL_BIT = 1;
  localparam int ST_OVF_BIT  = 2;

  // Instructions that need the long execution wait
  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  // Power-on init sequence: 8-bit/2-line, display on, entry mode, clear
  localparam int         INIT_LEN      = 4;
  localparam logic [7:0] INIT_FUNC_SET = 8'h38;
  localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
  localparam logic [7:0] INIT_ENTRY    = 8'h06;
  localparam logic [7:0] INIT_CLEAR    = 8'h01;

  function automatic lcd_cmd_t init_rom(input logic [1:0] idx);
    lcd_cmd_t c;
    c.rs = 1'b0;
    case (idx)
      2'd0:    c.data = INIT_FUNC_SET;
      2'd1:    c.data = INIT_DISP_ON;
      2'd2:    c.data = INIT_ENTRY;
      default: c.data = INIT_CLEAR;
    endcase
    return c;
  endfunction

  function automatic logic is_long_cmd(input lcd_cmd_t c);
    return !c.rs && ((c.data == OP_CLEAR) || (c.data == OP_HOME) ||
                     (c.data == OP_HOME_ALT));
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO of LCD commands. Storage is not reset; the
// pointers and the separate occupancy count define which entries are valid.
// A push while full is accepted only when a pop happens in the same cycle.
module lcd_cmd_fifo
  import lcd_pio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  lcd_cmd_t                 i_push_data,
  input  logic                     i_pop,
  output lcd_cmd_t                 o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  lcd_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);
  assign o_head  = mem[rd_ptr_q];
  assign o_count = count_q;

  // Entry storage, written at the tail on an accepted push
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_pio_driver.sv
// Consumer of the LCD PIO register: buffers CPU command writes and replays
// them onto HD44780-style pins with setup, enable pulse, hold and execution
// wait. Optional power-on init sequence enabled by LCD_INIT_SEQ_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for a command; issues the next one when present
// SETUP     | RS/DATA driven, EN low, setup time running
// PULSE     | EN high
// HOLD      | EN low, RS/DATA held
// EXEC      | waiting for the LCD to execute (long wait for clear/home)
// INIT_WAIT | power-on delay before the init sequence (optional)
module lcd_pio_driver
  import lcd_pio_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_CLR_CYC   = 82000,
  parameter int T_PWRUP_CYC = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lcd_wr,
  input  logic [31:0] i_lcd_wdata,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic [31:0] o_status
);

  localparam int T_MAX = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_EXEC_CYC)),
                              max2(T_CLR_CYC, T_PWRUP_CYC));
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR_CYC - 1);
`ifdef LCD_INIT_SEQ_EN
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP_CYC - 1);
`endif

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lcd_cmd_t         cmd_q, cmd_d;
  logic             on_q;
  logic             ovf_q;
  logic             start;
  logic             busy;

  logic             wr_cmd;
  logic             wr_ctrl;
  logic             drop;
  lcd_cmd_t         push_cmd;
  lcd_cmd_t         fifo_head;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;

  logic             unused_wdata_bits;
  logic             unused_fifo_count;

`ifdef LCD_INIT_SEQ_EN
  logic [2:0]       init_idx_q, init_idx_d;
  logic             init_adv;
  logic             init_pending;

  assign init_pending = (init_idx_q != 3'(INIT_LEN));
  assign init_idx_d   = init_adv ? (init_idx_q + 3'd1) : init_idx_q;
`endif

  assign unused_wdata_bits = ^i_lcd_wdata[29:9];
  assign unused_fifo_count = ^fifo_count;

  assign wr_ctrl       = i_lcd_wr && i_lcd_wdata[WD_CTRL_ONLY_BIT];
  assign wr_cmd        = i_lcd_wr && !i_lcd_wdata[WD_CTRL_ONLY_BIT];
  assign push_cmd.rs   = i_lcd_wdata[WD_RS_BIT];
  assign push_cmd.data = i_lcd_wdata[7:0];
  assign drop          = wr_cmd && fifo_full && !fifo_pop;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (wr_cmd),
    .i_push_data (push_cmd),
    .i_pop       (fifo_pop),
    .o_head      (fifo_head),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  // Backlight latch and sticky overflow flag, updated on every CPU write
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      on_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (i_lcd_wr) begin
      on_q <= i_lcd_wdata[WD_ON_BIT];
      if (wr_ctrl) begin
        ovf_q <= 1'b0;
      end else if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // FSM state, shared down-counter and the command driving the pins
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
`ifdef LCD_INIT_SEQ_EN
      state_q    <= INIT_WAIT;
      cnt_q      <= LD_PWRUP;
      init_idx_q <= '0;
`else
      state_q    <= IDLE;
      cnt_q      <= '0;
`endif
      cmd_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
`ifdef LCD_INIT_SEQ_EN
      init_idx_q <= init_idx_d;
`endif
    end
  end

  // Next-state: each timed state reloads the counter on entry and leaves at zero
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    fifo_pop = 1'b0;
    start    = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    init_adv = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef LCD_INIT_SEQ_EN
        if (init_pending) begin
          cmd_d    = init_rom(init_idx_q[1:0]);
          init_adv = 1'b1;
          start    = 1'b1;
        end else
`endif
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          start    = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = LD_EN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = EXEC;
          cnt_d   = is_long_cmd(cmd_q) ? LD_CLR : LD_EXEC;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef LCD_INIT_SEQ_EN
      INIT_WAIT: begin
        if (cnt_q == '0) begin
          cmd_d    = init_rom(init_idx_q[1:0]);
          init_adv = 1'b1;
          start    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (start) begin
      state_d = SETUP;
      cnt_d   = LD_SETUP;
    end
  end

`ifdef LCD_INIT_SEQ_EN
  assign busy = (state_q != IDLE) || !fifo_empty || init_pending;
`else
  assign busy = (state_q != IDLE) || !fifo_empty;
`endif

  // Status word assembled from registered state only
  always_comb begin
    o_status              = '0;
    o_status[ST_BUSY_BIT] = busy;
    o_status[ST_FULL_BIT] = fifo_full;
    o_status[ST_OVF_BIT]  = ovf_q;
  end

  assign o_lcd_data = cmd_q.data;
  assign o_lcd_rs   = cmd_q.rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = (state_q == PULSE);
  assign o_lcd_on   = on_q;

endmodule

// File: tb/tb_lcd_pio_driver.sv
// Scoreboard bench for lcd_pio_driver. A transaction-level model predicts,
// per clock edge, which commands are accepted or dropped, when each one
// starts, and the status word; expected pulses go into a queue that an
// independent monitor drains as EN pulses appear on the pins.
module tb_lcd_pio_driver;

  localparam int FIFO_DEPTH = 4;
  localparam int T_SETUP    = 2;
  localparam int T_EN       = 3;
  localparam int T_HOLD     = 1;
  localparam int T_EXEC     = 5;
  localparam int T_CLR      = 9;
  localparam int T_PWRUP    = 10;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        wr;
  logic [31:0] wdata;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [31:0] status;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_pio_driver #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .T_SETUP_CYC (T_SETUP),
    .T_EN_CYC    (T_EN),
    .T_HOLD_CYC  (T_HOLD),
    .T_EXEC_CYC  (T_EXEC),
    .T_CLR_CYC   (T_CLR),
    .T_PWRUP_CYC (T_PWRUP)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_b),
    .i_lcd_wr    (wr),
    .i_lcd_wdata (wdata),
    .o_lcd_data  (lcd_data),
    .o_lcd_rs    (lcd_rs),
    .o_lcd_rw    (lcd_rw),
    .o_lcd_en    (lcd_en),
    .o_lcd_on    (lcd_on),
    .o_status    (status)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [8:0]  m_fifo[$];
  int          m_next_pop   = 0;
  int          m_busy_until = 0;
  int          m_init_rem   = 0;
  bit          m_on         = 1'b0;
  bit          m_ovf        = 1'b0;
`ifdef LCD_INIT_SEQ_EN
  int          m_rom_idx    = 0;
  logic [8:0]  rom [4]      = '{9'h038, 9'h00C, 9'h006, 9'h001};
`endif

  // Expected values for the most recent edge, read by the monitor
  logic [8:0]  exp_cmd_q[$];
  int          exp_rise_q[$];
  bit          exp_rst    = 1'b1;
  bit          exp_on     = 1'b0;
  logic [31:0] exp_status = '0;

  function automatic int dur_of(logic [8:0] c);
    bit long_wait;
    long_wait = !c[8] && (c[7:0] >= 8'd1) && (c[7:0] <= 8'd3);
    return T_SETUP + T_EN + T_HOLD + (long_wait ? T_CLR : T_EXEC);
  endfunction

  task automatic issue(int n, logic [8:0] c);
    exp_cmd_q.push_back(c);
    exp_rise_q.push_back(n + T_SETUP);
    m_busy_until = n + dur_of(c);
    m_next_pop   = n + dur_of(c) + 1;
  endtask

  // Predict the effect of clock edge n given the inputs present at it
  task automatic model_step(int n, bit r, bit w, logic [31:0] d);
    bit busy;
    if (!r) begin
      m_fifo.delete();
      exp_cmd_q.delete();
      exp_rise_q.delete();
      m_on         = 1'b0;
      m_ovf        = 1'b0;
      m_busy_until = 0;
      m_next_pop   = 0;
      m_init_rem   = 0;
`ifdef LCD_INIT_SEQ_EN
      m_init_rem   = 4;
      m_rom_idx    = 0;
      m_next_pop   = n + T_PWRUP;
`endif
      exp_rst = 1'b1;
    end else begin
      exp_rst = 1'b0;
      if (n >= m_next_pop) begin
`ifdef LCD_INIT_SEQ_EN
        if (m_init_rem > 0) begin
          issue(n, rom[m_rom_idx]);
          m_rom_idx++;
          m_init_rem--;
        end else
`endif
        if (m_fifo.size() > 0) begin
          issue(n, m_fifo.pop_front());
        end
      end
      if (w) begin
        m_on = d[31];
        if (d[30]) m_ovf = 1'b0;
        else if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back({d[8], d[7:0]});
        else m_ovf = 1'b1;
      end
    end
    busy = (n < m_busy_until) || (m_fifo.size() > 0) || (m_init_rem > 0);
    exp_on     = m_on;
    exp_status = {29'b0, m_ovf, (m_fifo.size() == FIFO_DEPTH), busy};
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic tick(bit r, bit w, logic [31:0] d);
    @(negedge clk);
    #1;
    rst_b = r;
    wr    = w;
    wdata = d;
    model_step(cyc + 1, r, w, d);
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, $urandom);
  endtask

  // Monitor: per-cycle status/pin checks and pulse scoreboard
  initial begin : monitor
    bit         prev_en;
    int         width;
    logic [8:0] cur;
    logic [8:0] ec;
    int         er;
    prev_en = 1'b0;
    width   = 0;
    cur     = '0;
    forever begin
      @(negedge clk);
      check("status", status, exp_status);
      check("lcd_on", {31'b0, lcd_on}, {31'b0, exp_on});
      check("lcd_rw", {31'b0, lcd_rw}, 32'd0);
      if (exp_rst) begin
        check("reset_pins", {22'b0, lcd_en, lcd_rs, lcd_data}, 32'd0);
        prev_en = 1'b0;
        width   = 0;
      end else begin
        if (lcd_en && !prev_en) begin
          if (exp_cmd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse at cycle %0d: got rs=%0b data=%0h expected no pulse",
                     cyc, lcd_rs, lcd_data);
          end else begin
            ec = exp_cmd_q.pop_front();
            er = exp_rise_q.pop_front();
            check("pulse_cmd", {23'b0, lcd_rs, lcd_data}, {23'b0, ec});
            check("pulse_rise_cycle", cyc, er);
          end
          cur   = {lcd_rs, lcd_data};
          width = 1;
        end else if (lcd_en) begin
          width++;
        end else if (prev_en) begin
          check("en_width", width, T_EN);
          check("hold_pins", {23'b0, lcd_rs, lcd_data}, {23'b0, cur});
        end
        prev_en = lcd_en;
      end
    end
  end

  // Stimulus
  initial begin : stimulus
    bit          r, w;
    logic [31:0] d;
    rst_b = 1'b0;
    wr    = 1'b0;
    wdata = '0;
    model_step(1, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    repeat (3) idle();

    tick(1'b1, 1'b1, 32'h8000_0141);
    repeat (30) idle();
    tick(1'b1, 1'b1, 32'h0000_0001);
    repeat (30) idle();
    tick(1'b1, 1'b1, 32'h0000_0080);
    repeat (20) idle();

    tick(1'b1, 1'b1, 32'h8000_0155);
    repeat (2) idle();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 32'h8000_0160 + 32'(i));
    repeat (150) idle();
    tick(1'b1, 1'b1, 32'h4000_0000);
    repeat (20) idle();

    tick(1'b1, 1'b1, 32'h8000_01AA);
    repeat (3) idle();
    tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    repeat (30) idle();

    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 299) != 0);
      w = ($urandom_range(0, 3) == 0);
      d = $urandom;
      if ($urandom_range(0, 7) != 0) d[30] = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        d[7:0] = 8'($urandom_range(1, 3));
        d[8]   = 1'($urandom_range(0, 1));
      end
      tick(r, w, d);
    end

    for (int k = 0; k < 1000; k++) begin
      if (m_fifo.size() == 0 && m_init_rem == 0 && cyc >= m_busy_until + 2) break;
      idle();
    end
    repeat (5) idle();
    check("drained", exp_cmd_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
